// File: rtl/demux16x1_wr_if.sv
// rtl/demux16x1_wr_if.sv - write-request and one-hot lane handshake bundle for demux16x1_wr
interface demux16x1_wr_if #(
   parameter int N = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_sel;
   logic [N-1:0]  in_data;
   logic [15:0]   out_valid;
   logic [15:0]   out_ready;
   logic [N-1:0]  out_data;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/demux16x1_wr.sv
// rtl/demux16x1_wr.sv - registered 1-to-16 write demux with input FIFO and per-lane capture
// Optional lane locking is built in when DEMUX16_LOCK_EN is defined.
module demux16x1_wr #(
   parameter int          N         = 32,
   parameter int          DEPTH     = 2,
   parameter logic [15:0] LOCK_MASK = 16'h0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   demux16x1_wr_if.slave          bus,
   output logic [16*N-1:0]        lane_q,
   output logic [$clog2(DEPTH):0] count,
   output logic                   lock_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state, state_n;
   logic [3:0]      mem_sel  [DEPTH];
   logic [N-1:0]    mem_data [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [3:0]      sel_r;
   logic [N-1:0]    data_r;
   logic [3:0]      head_sel;
   logic            empty, push, pop, accept, lock_hit;

   assign head_sel     = mem_sel[rd_ptr];
   assign empty        = (count == '0);
   // Depends only on registered occupancy, so out_ready never reaches in_ready.
   assign bus.in_ready = (count != CW'(DEPTH));
   assign push         = bus.in_valid && bus.in_ready;

`ifdef DEMUX16_LOCK_EN
   assign lock_hit = !empty && LOCK_MASK[head_sel];
`else
   assign lock_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n       = state;
      bus.out_valid = '0;
      bus.out_data  = '0;
      accept        = 1'b0;
      if (state == HOLD) begin
         bus.out_valid = 16'(1) << sel_r;
         bus.out_data  = data_r;
         accept        = bus.out_ready[sel_r];
      end
      pop = !empty && ((state == IDLE) || accept);
      // A locked head is consumed without presenting, so the next entry waits a cycle.
      if (pop)         state_n = lock_hit ? IDLE : HOLD;
      else if (accept) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_sel[i]  <= '0;
            mem_data[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         sel_r    <= '0;
         data_r   <= '0;
         lane_q   <= '0;
         lock_err <= 1'b0;
      end else begin
         if (push) begin
            mem_sel[wr_ptr]  <= bus.in_sel;
            mem_data[wr_ptr] <= bus.in_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (!lock_hit) begin
               sel_r  <= head_sel;
               data_r <= mem_data[rd_ptr];
            end
         end
         if (accept)
            lane_q[sel_r*N +: N] <= data_r;
         count    <= count + CW'(push) - CW'(pop);
         lock_err <= pop && lock_hit;
      end
   end
endmodule
